// File: rtl/q_timed_issue.sv
// Timed issue scheduler: queues {instruction, wait} pairs and presents each one after its wait has elapsed.
// Latency: push-to-valid is in_wait+1 cycles from an idle, empty queue; back-to-back zero-wait entries issue every cycle.
// Backpressure: in_ready_o drops only when the FIFO is full; out_valid_o holds until out_ready_i, and late_err_o records the stall.
module q_timed_issue #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int INST_W = 64,
    parameter int WAIT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [INST_W-1:0] in_inst_i,
    input  logic [WAIT_W-1:0] in_wait_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [INST_W-1:0] out_inst_o,
    input  logic              out_ready_i,
    output logic [AW:0]       count_o,
    output logic              busy_o,
    output logic              overflow_err_o,
    output logic              late_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [WAIT_W-1:0] wait_mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [WAIT_W-1:0] timer_q, timer_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              ovf_q, ovf_d;
    logic              late_q, late_d;
    logic              full, push, pop;

    assign full           = (count_q == FULL_CNT);
    assign in_ready_o     = ~full;
    assign push           = in_valid_i & ~full & ~flush_i;
    assign out_valid_o    = (state_q == S_ISSUE);
    assign out_inst_o     = out_valid_o ? hold_q : '0;
    assign count_o        = count_q;
    assign busy_o         = (state_q != S_IDLE) || (count_q != '0);
    assign overflow_err_o = ovf_q;
    assign late_err_o     = late_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en_i && count_q != '0) pop = 1'b1;
            end
            S_WAIT: begin
                // Load never enters WAIT with a zero timer, so this cannot underflow.
                if (en_i) begin
                    timer_d = timer_q - WAIT_W'(1);
                    if (timer_q == WAIT_W'(1)) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (out_ready_i) begin
                    if (en_i && count_q != '0) pop = 1'b1;
                    else                       state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) pop = 1'b0;
        if (pop) begin
            hold_d  = inst_mem[rd_ptr_q];
            timer_d = wait_mem[rd_ptr_q];
            state_d = (wait_mem[rd_ptr_q] == '0) ? S_ISSUE : S_WAIT;
        end
        if (flush_i) begin
            state_d = S_IDLE;
            timer_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d  = ovf_q  | (in_valid_i & full);
        late_d = late_q | (out_valid_o & ~out_ready_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            late_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= in_inst_i;
            wait_mem[wr_ptr_q] <= in_wait_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
            late_q   <= late_d;
        end
    end

endmodule

// File: tb/tb_q_timed_issue.sv
// Bench for q_timed_issue: per-scenario tasks with inline cycle checks plus an issue-order scoreboard.
// Inputs change 1 time unit after the rising edge; handshakes are scored on the falling edge.
module tb_q_timed_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        flush_i;
    logic        in_valid_i;
    logic [63:0] in_inst_i;
    logic [15:0] in_wait_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [63:0] out_inst_o;
    logic        out_ready_i;
    logic [4:0]  count_o;
    logic        busy_o;
    logic        overflow_err_o;
    logic        late_err_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb [$];

    always #5 clk_i = ~clk_i;

    q_timed_issue dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_inst_i      (in_inst_i),
        .in_wait_i      (in_wait_i),
        .in_ready_o     (in_ready_o),
        .out_valid_o    (out_valid_o),
        .out_inst_o     (out_inst_o),
        .out_ready_i    (out_ready_i),
        .count_o        (count_o),
        .busy_o         (busy_o),
        .overflow_err_o (overflow_err_o),
        .late_err_o     (late_err_o)
    );

    // Scoreboard: every accepted handshake must match the oldest expected word.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_issue got %h want none", out_inst_o);
            end else begin
                logic [63:0] exp_w;
                exp_w = sb.pop_front();
                if (out_inst_o !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_order got %h want %h", out_inst_o, exp_w);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [15:0] w, input bit accept);
        in_valid_i = 1'b1;
        in_inst_i  = d;
        in_wait_i  = w;
        if (accept) sb.push_back(d);
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; en_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
        in_inst_i = '0; in_wait_i = '0; out_ready_i = 1'b1;
        step(); step();
        n_checks++; if (in_ready_o !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_inst_o !== 64'h0)    begin n_fail++; $display("FAIL reset_out_inst got %h want 0", out_inst_o); end
        n_checks++; if (count_o !== 5'd0)        begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_checks++; if (busy_o !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (overflow_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_err_o); end
        n_checks++; if (late_err_o !== 1'b0)     begin n_fail++; $display("FAIL reset_late got %b want 0", late_err_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_op;
        en_i = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push(64'hA000_0000_0000_0000 | 64'(i), 16'd20, 1'b1);
        step(); step();
        n_checks++; if (count_o !== 5'd2)     begin n_fail++; $display("FAIL midrst_count_before got %0d want 2", count_o); end
        n_checks++; if (busy_o !== 1'b1)      begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_before got %b want 0", out_valid_o); end
        rst_ni = 1'b0;
        #1;
        n_checks++; if (count_o !== 5'd0)     begin n_fail++; $display("FAIL midrst_count got %0d want 0", count_o); end
        n_checks++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_o); end
        n_checks++; if (in_ready_o !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid_o); end
        sb.delete();
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL midrst_idle cycle %0d got valid=%b busy=%b want 0/0", k, out_valid_o, busy_o);
            end
        end
    endtask

    task automatic test_single;
        logic [63:0] d;
        d = {$urandom, $urandom};
        en_i = 1'b1; out_ready_i = 1'b1;
        push(d, 16'd5, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            n_checks++; if (out_valid_o !== (k == 6)) begin
                n_fail++; $display("FAIL single_valid edge %0d got %b want %b", k, out_valid_o, (k == 6));
            end
            n_checks++; if (busy_o !== (k < 7)) begin
                n_fail++; $display("FAIL single_busy edge %0d got %b want %b", k, busy_o, (k < 7));
            end
            n_checks++; if (out_inst_o !== ((k == 6) ? d : 64'h0)) begin
                n_fail++; $display("FAIL single_inst edge %0d got %h want %h", k, out_inst_o, (k == 6) ? d : 64'h0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] w [3];
        logic [15:0] wt [3];
        logic        exp_v [7];
        logic [63:0] exp_d [7];
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        wt    = '{16'd0, 16'd0, 16'd2};
        for (int i = 0; i < 3; i++) w[i] = {32'hB0B0_0000 | 32'(i), $urandom};
        exp_d = '{64'h0, w[0], w[1], 64'h0, 64'h0, w[2], 64'h0};
        en_i = 1'b1; out_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) push(w[k], wt[k], 1'b1);
            else       step();
            n_checks++; if (out_valid_o !== exp_v[k] || out_inst_o !== exp_d[k]) begin
                n_fail++; $display("FAIL b2b edge %0d got v=%b d=%h want v=%b d=%h", k, out_valid_o, out_inst_o, exp_v[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_fill_overflow;
        en_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push({32'hF111_0000 | 32'(i), $urandom}, 16'd0, 1'b1);
            n_checks++; if (count_o !== 5'(i + 1) || in_ready_o !== (i < 15)) begin
                n_fail++; $display("FAIL fill push %0d got count=%0d rdy=%b want %0d/%b", i, count_o, in_ready_o, i + 1, (i < 15));
            end
        end
        push(64'hDEAD_DEAD_DEAD_DEAD, 16'd0, 1'b0);
        n_checks++; if (overflow_err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_err_o); end
        n_checks++; if (count_o !== 5'd16)       begin n_fail++; $display("FAIL ovf_count got %0d want 16", count_o); end
        en_i = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) step();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain_timeout got %0d left want 0", sb.size()); end
        step();
        n_checks++; if (count_o !== 5'd0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_done got count=%0d busy=%b want 0/0", count_o, busy_o);
        end
        n_checks++; if (overflow_err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow_err_o); end
    endtask

    task automatic test_late_and_enable;
        logic [63:0] d;
        d = {$urandom, $urandom};
        en_i = 1'b1; out_ready_i = 1'b0;
        push(d, 16'd0, 1'b1);
        step();
        n_checks++; if (out_valid_o !== 1'b1 || out_inst_o !== d || late_err_o !== 1'b0) begin
            n_fail++; $display("FAIL late_first got v=%b d=%h late=%b want 1/%h/0", out_valid_o, out_inst_o, late_err_o, d);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) en_i = 1'b0;
            step();
            n_checks++; if (out_valid_o !== 1'b1 || out_inst_o !== d || late_err_o !== 1'b1) begin
                n_fail++; $display("FAIL late_hold %0d got v=%b d=%h late=%b want 1/%h/1", k, out_valid_o, out_inst_o, late_err_o, d);
            end
        end
        en_i = 1'b1; out_ready_i = 1'b1;
        step();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL late_release got %b want 0", out_valid_o); end

        d = {$urandom, $urandom};
        push(d, 16'd4, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step();
            n_checks++; if (out_valid_o !== (k == 8)) begin
                n_fail++; $display("FAIL en_gap edge %0d got %b want %b", k, out_valid_o, (k == 8));
            end
            if (k == 1) en_i = 1'b0;
            if (k == 4) en_i = 1'b1;
        end
    endtask

    task automatic test_flush;
        en_i = 1'b0; out_ready_i = 1'b1;
        in_valid_i = 1'b1; step(); in_valid_i = 1'b0;
        sb.delete();
        for (int i = 0; i < 17; i++) push({32'hC0DE_0000 | 32'(i), $urandom}, 16'd1, 1'b0);
        n_checks++; if (count_o !== 5'd16 || overflow_err_o !== 1'b1 || late_err_o !== 1'b1) begin
            n_fail++; $display("FAIL preflush got count=%0d ovf=%b late=%b want 16/1/1", count_o, overflow_err_o, late_err_o);
        end
        flush_i = 1'b1;
        push(64'h5555_AAAA_5555_AAAA, 16'd0, 1'b0);
        flush_i = 1'b0;
        n_checks++; if (count_o !== 5'd0)        begin n_fail++; $display("FAIL flush_count got %0d want 0", count_o); end
        n_checks++; if (out_valid_o !== 1'b0)    begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid_o); end
        n_checks++; if (overflow_err_o !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got %b want 0", overflow_err_o); end
        n_checks++; if (late_err_o !== 1'b0)     begin n_fail++; $display("FAIL flush_late got %b want 0", late_err_o); end
        en_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL flush_quiet cycle %0d got v=%b busy=%b want 0/0", k, out_valid_o, busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_single();
        test_back_to_back();
        test_fill_overflow();
        test_late_and_enable();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
